mul_seq_ctrl: RTL

- Multi-cycle 64x64 -> 64-bit multiply sequencer for the execute stage.
- Has no arithmetic of its own. It time-shares one external 64-bit add/sub unit by driving that unit's operands and sub select each cycle and consuming its sum and carry.
- Performs operand sign handling, 64 shift-add iterations and result negation, then presents product plus NZVC-style flags.
- The pipeline stalls on busy.

---
 rtl/mul_seq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle 64x64 -> 64-bit multiply sequencer.
//   Owns no adder. It time-shares an external 64-bit add/sub unit: each cycle
//   it drives add_a/add_b/add_sub and consumes add_sum/add_carry.
//   Flow: IDLE -> NEG_A -> NEG_B -> ACC (64 shift-add steps) -> NEG_P -> IDLE.
//   Operands are reduced to magnitudes, multiplied as unsigned, and the result
//   is re-negated when the signs differ.
// Ports:
//   clk, reset        clock, async active-high reset
//   start/is_signed   request; sampled with op_a/op_b only in IDLE
//   op_a, op_b        multiplicand, multiplier
//   add_a/add_b/add_sub   operands and subtract select to the shared adder
//   add_sum/add_carry     combinational result from the shared adder
//   busy              high while an operation is in flight
//   done              one-cycle pulse; product/flags valid from then on
//   product, flags    low 64 bits of the product; flags = {N, Z, V, C=0}
module mul_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ACC, NEG_P} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg, mcand, mplier, acc;
  logic             sgn_reg, sign_a, sign_b, ovf, lost;
  logic [5:0]       cnt;

  logic             neg;
  logic [WIDTH-1:0] final_p;
  logic             v_final;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = NEG_A;
      NEG_A:   state_nxt = NEG_B;
      NEG_B:   state_nxt = ACC;
      ACC:     if (cnt == 6'd63) state_nxt = NEG_P;
      NEG_P:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: adder steering and busy
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      NEG_A: begin add_b = a_reg; add_sub = 1'b1; end
      NEG_B: begin add_b = b_reg; add_sub = 1'b1; end
      ACC:   begin add_a = acc; add_b = mcand; end
      NEG_P: begin add_b = acc; add_sub = 1'b1; end
      default: ;
    endcase
  end

  // Result stage. A negative result may reach magnitude 2^63; any larger
  // magnitude (or a positive one with bit 63 set) does not fit in signed.
  always_comb begin
    neg     = sgn_reg & (sign_a ^ sign_b);
    final_p = neg ? add_sum : acc;
    v_final = ovf;
    if (sgn_reg)
      v_final = ovf | (acc[WIDTH-1] & ~(neg & (acc == MIN_NEG)));
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      ovf     <= 1'b0;
      lost    <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
      flags   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_reg   <= op_a;
          b_reg   <= op_b;
          sgn_reg <= is_signed;
          acc     <= '0;
          ovf     <= 1'b0;
          lost    <= 1'b0;
          cnt     <= '0;
        end
        NEG_A: begin
          sign_a <= sgn_reg & a_reg[WIDTH-1];
          mcand  <= (sgn_reg & a_reg[WIDTH-1]) ? add_sum : a_reg;
        end
        NEG_B: begin
          sign_b <= sgn_reg & b_reg[WIDTH-1];
          mplier <= (sgn_reg & b_reg[WIDTH-1]) ? add_sum : b_reg;
        end
        ACC: begin
          // 'lost' marks multiplicand bits already shifted past bit 63; adding
          // such a term means the true partial product exceeds 64 bits.
          if (mplier[0]) begin
            acc <= add_sum;
            ovf <= ovf | add_carry | lost;
          end
          mcand  <= mcand << 1;
          lost   <= lost | mcand[WIDTH-1];
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        NEG_P: begin
          product <= final_p;
          flags   <= {final_p[WIDTH-1], (final_p == '0), v_final, 1'b0};
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
